// File: rtl/ledr_pwm_driver.sv
// LEDR output stage: global PWM brightness plus optional blinking, with a 4-register Avalon-MM slave.
// Optional gamma correction of the duty value is enabled by defining LEDR_PWM_GAMMA_EN.
module ledr_pwm_driver #(
  parameter int WIDTH        = 10,
  parameter int PRESCALE_RST = 195,
  parameter int DUTY_RST     = 255,
  parameter int BLINK_RST    = 500
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] led_in,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] led_out
);

  localparam logic [1:0]  ADDR_CTRL     = 2'd0;
  localparam logic [1:0]  ADDR_PRESCALE = 2'd1;
  localparam logic [1:0]  ADDR_BLINK    = 2'd2;
  localparam logic [1:0]  ADDR_STATUS   = 2'd3;
  localparam logic [7:0]  DUTY_INIT     = 8'(DUTY_RST);
  localparam logic [15:0] PRESCALE_INIT = 16'(PRESCALE_RST);
  localparam logic [15:0] BLINK_INIT    = 16'(BLINK_RST);

  logic        enable;
  logic        blink_en;
  logic [7:0]  duty;
  logic [15:0] prescale;
  logic [15:0] blink_period;
  logic [15:0] pre_cnt;
  logic [7:0]  pwm_cnt;
  logic [15:0] frame_cnt;
  logic        phase;
  logic [7:0]  duty_eff;
  logic [7:0]  gamma_status;

  logic        wr_en;
  logic        wr_ctrl;
  logic        wr_prescale;
  logic        wr_blink;
  logic        tick;
  logic        frame_end;
  logic [15:0] period_eff;
  logic        frame_last;
  logic        pwm_on;
  logic        unused_wdata;

  assign wr_en       = chipselect && !write_n;
  assign wr_ctrl     = wr_en && (address == ADDR_CTRL);
  assign wr_prescale = wr_en && (address == ADDR_PRESCALE);
  assign wr_blink    = wr_en && (address == ADDR_BLINK);

  assign unused_wdata = ^{writedata[31:16], writedata[7:2]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable       <= 1'b1;
      blink_en     <= 1'b0;
      duty         <= DUTY_INIT;
      prescale     <= PRESCALE_INIT;
      blink_period <= BLINK_INIT;
    end else begin
      if (wr_ctrl) begin
        enable   <= writedata[0];
        blink_en <= writedata[1];
        duty     <= writedata[15:8];
      end
      if (wr_prescale) prescale <= writedata[15:0];
      if (wr_blink) blink_period <= writedata[15:0];
    end
  end

  // A PRESCALE write restarts the frame, so it also swallows any frame_end in that cycle.
  assign tick      = (pre_cnt == prescale);
  assign frame_end = tick && (pwm_cnt == 8'hFF) && !wr_prescale;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else if (wr_prescale) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
      pwm_cnt <= pwm_cnt + 8'd1;
    end else begin
      pre_cnt <= pre_cnt + 16'd1;
    end
  end

  assign period_eff = (blink_period == 16'd0) ? 16'd1 : blink_period;
  assign frame_last = (frame_cnt == period_eff - 16'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else if (wr_blink) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else if (frame_end) begin
      if (frame_last) begin
        frame_cnt <= '0;
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

`ifdef LEDR_PWM_GAMMA_EN
  localparam logic [7:0] DUTY_EFF_INIT = 8'((DUTY_RST * DUTY_RST) >> 8);

  // Squared duty is registered, so it trails a CTRL write by one clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) duty_eff <= DUTY_EFF_INIT;
    else          duty_eff <= 8'((16'(duty) * 16'(duty)) >> 8);
  end

  assign gamma_status = duty_eff;
`else
  assign duty_eff     = duty;
  assign gamma_status = 8'd0;
`endif

  assign pwm_on = (pwm_cnt < duty_eff);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    led_out <= '0;
    else if (enable) led_out <= led_in & {WIDTH{pwm_on && (!blink_en || phase)}};
    else             led_out <= '0;
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_CTRL:     readdata = {16'd0, duty, 6'd0, blink_en, enable};
      ADDR_PRESCALE: readdata = {16'd0, prescale};
      ADDR_BLINK:    readdata = {16'd0, blink_period};
      ADDR_STATUS:   readdata = {8'd0, gamma_status, pwm_cnt, 7'd0, phase};
      default:       readdata = 32'd0;
    endcase
  end

endmodule
